game_state_fsm: RTL and testbench

Top-level game sequencer sitting directly downstream of the game logic core. It consumes the three base-destroyed flags, the kill counter and the player's click, and runs the menu, play, game-over and win sequence. It also drives the reset that holds the game logic core idle outside of play, and latches the final and best scores for the display path.

---
 rtl/game_state_pkg.sv | 21 ++
 rtl/game_state_fsm_if.sv | 32 +++
 rtl/game_state_fsm_rise_edge_detect.sv | 24 ++
 rtl/game_state_fsm.sv | 119 +++++++++++
 tb/tb_game_state_fsm.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/game_state_pkg.sv
// Shared types and default parameters for the game sequencer.
// State encoding doubles as the screen-select code seen by the display path.
package game_state_pkg;

  typedef enum logic [2:0] {
    MENU  = 3'd0,
    CLEAR = 3'd1,
    PLAY  = 3'd2,
    OVER  = 3'd3,
    WIN   = 3'd4
  } game_state_t;

  localparam int WIN_KILLS_DEF       = 50;
  localparam int GAME_RST_CYCLES_DEF = 16;
  localparam int RESTART_HOLDOFF_DEF = 25_000_000;

  function automatic logic [1:0] bases_alive(input logic [2:0] lost);
    return 2'd3 - (2'(lost[0]) + 2'(lost[1]) + 2'(lost[2]));
  endfunction

endpackage

// File: rtl/game_state_fsm_if.sv
// Bundle between the game logic core / display path and the game sequencer.
// master = core and display side, slave = sequencer.
interface game_state_fsm_if #(
  parameter int OUT_WIDTH = 8
);
  import game_state_pkg::*;

  logic                 click;
  logic                 base1_nuked;
  logic                 base2_nuked;
  logic                 base3_nuked;
  logic [OUT_WIDTH-1:0] killcount;

  logic                 game_rst;
  game_state_t          state;
  logic                 playing;
  logic                 win;
  logic [1:0]           bases_left;
  logic [OUT_WIDTH-1:0] score;
  logic [OUT_WIDTH-1:0] high_score;

  modport master (
    output click, base1_nuked, base2_nuked, base3_nuked, killcount,
    input  game_rst, state, playing, win, bases_left, score, high_score
  );

  modport slave (
    input  click, base1_nuked, base2_nuked, base3_nuked, killcount,
    output game_rst, state, playing, win, bases_left, score, high_score
  );

endinterface

// File: rtl/game_state_fsm_rise_edge_detect.sv
// Registered rising-edge detector: rise pulses one cycle after din goes high.
// Latency 1 cycle; no backpressure. RESET_VAL=1 suppresses an edge for a level held through reset.
module rise_edge_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic din_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      din_q <= RESET_VAL;
      rise  <= 1'b0;
    end else begin
      din_q <= din;
      rise  <= din & ~din_q;
    end
  end

endmodule

// File: rtl/game_state_fsm.sv
// Menu / play / game-over / win sequencer; holds the game core in reset outside PLAY, tracks scores.
// Outputs decoded from registers only (click to state change 2 cycles); no backpressure.
module game_state_fsm
  import game_state_pkg::*;
#(
  parameter int OUT_WIDTH       = 8,
  parameter int WIN_KILLS       = WIN_KILLS_DEF,
  parameter int GAME_RST_CYCLES = GAME_RST_CYCLES_DEF,
  parameter int RESTART_HOLDOFF = RESTART_HOLDOFF_DEF
) (
  input  logic              clk,
  input  logic              rst,
  game_state_fsm_if.slave   bus
);

  localparam int CNT_MAX = (GAME_RST_CYCLES > RESTART_HOLDOFF) ? GAME_RST_CYCLES : RESTART_HOLDOFF;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]     CLR_LAST   = CNT_W'(GAME_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]     HOLD_LAST  = CNT_W'(RESTART_HOLDOFF - 1);
  localparam logic [OUT_WIDTH-1:0] WIN_THRESH = OUT_WIDTH'(WIN_KILLS);

  game_state_t          state_q;
  game_state_t          state_nxt;
  logic [CNT_W-1:0]     cnt_q;
  logic                 cnt_done;
  logic [2:0]           lost_q;
  logic [2:0]           lost_nxt;
  logic                 all_lost;
  logic                 kill_win;
  logic [OUT_WIDTH-1:0] score_q;
  logic [OUT_WIDTH-1:0] high_q;
  logic                 click_rise;

  rise_edge_detect #(
    .RESET_VAL (1'b1)
  ) u_click_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.click),
    .rise (click_rise)
  );

  // A base lost this very cycle already counts toward game over.
  assign lost_nxt = lost_q | {bus.base3_nuked, bus.base2_nuked, bus.base1_nuked};
  assign all_lost = &lost_nxt;
  assign kill_win = (bus.killcount >= WIN_THRESH);
  assign cnt_done = (state_q == CLEAR) ? (cnt_q == CLR_LAST) : (cnt_q == HOLD_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MENU;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      MENU:     if (click_rise) state_nxt = CLEAR;
      CLEAR:    if (cnt_done) state_nxt = PLAY;
      PLAY: begin
        if (all_lost)      state_nxt = OVER;
        else if (kill_win) state_nxt = WIN;
      end
      OVER, WIN: if (cnt_done && click_rise) state_nxt = CLEAR;
      default:  state_nxt = MENU;
    endcase
  end

  always_comb begin
    bus.game_rst = 1'b1;
    bus.playing  = 1'b0;
    bus.win      = 1'b0;
    case (state_q)
      PLAY: begin
        bus.game_rst = 1'b0;
        bus.playing  = 1'b1;
      end
      WIN:     bus.win = 1'b1;
      default: ;
    endcase
  end

  assign bus.state      = state_q;
  assign bus.bases_left = bases_alive(lost_q);
  assign bus.score      = score_q;
  assign bus.high_score = high_q;

  // Shared counter: restarts on every state change and saturates at the active limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (state_nxt != state_q) begin
      cnt_q <= '0;
    end else if ((state_q == CLEAR || state_q == OVER || state_q == WIN) && !cnt_done) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lost_q  <= '0;
      score_q <= '0;
      high_q  <= '0;
    end else if (state_q == CLEAR && state_nxt == PLAY) begin
      lost_q  <= '0;
      score_q <= '0;
    end else if (state_q == PLAY) begin
      lost_q  <= lost_nxt;
      score_q <= bus.killcount;
      if (state_nxt != PLAY && bus.killcount > high_q) begin
        high_q <= bus.killcount;
      end
    end
  end

endmodule

// File: tb/tb_game_state_fsm.sv
// Directed table-driven bench for game_state_fsm with WIN_KILLS=5, GAME_RST_CYCLES=4, RESTART_HOLDOFF=10.
module tb_game_state_fsm;
  import game_state_pkg::*;

  logic clk;
  logic rst;

  game_state_fsm_if #(.OUT_WIDTH(8)) bus ();

  game_state_fsm #(
    .OUT_WIDTH       (8),
    .WIN_KILLS       (5),
    .GAME_RST_CYCLES (4),
    .RESTART_HOLDOFF (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        click;
    logic        b1;
    logic        b2;
    logic        b3;
    logic [7:0]  kill;
    game_state_t st;
    logic [1:0]  bases;
    logic [7:0]  score;
    logic [7:0]  high;
  } vec_t;

  vec_t vecs[$];
  int   n_chk;
  int   n_pass;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic add(input logic c, input logic b1, input logic b2, input logic b3,
                     input int k, input game_state_t s, input int bl, input int sc, input int hs);
    vec_t v;
    v.click = c;
    v.b1    = b1;
    v.b2    = b2;
    v.b3    = b3;
    v.kill  = 8'(k);
    v.st    = s;
    v.bases = 2'(bl);
    v.score = 8'(sc);
    v.high  = 8'(hs);
    vecs.push_back(v);
  endtask

  task automatic chk_all(input string tag, input game_state_t s, input int bl, input int sc, input int hs);
    chk({tag, ".state"},      int'(bus.state),      int'(s));
    chk({tag, ".game_rst"},   int'(bus.game_rst),   (s == PLAY) ? 0 : 1);
    chk({tag, ".playing"},    int'(bus.playing),    (s == PLAY) ? 1 : 0);
    chk({tag, ".win"},        int'(bus.win),        (s == WIN) ? 1 : 0);
    chk({tag, ".bases_left"}, int'(bus.bases_left), bl);
    chk({tag, ".score"},      int'(bus.score),      sc);
    chk({tag, ".high_score"}, int'(bus.high_score), hs);
  endtask

  // OVER/WIN holdoff then restart: rows j=0..last_in hold the end state, then 4 CLEAR rows, then PLAY.
  task automatic add_restart(input game_state_t s, input int bl, input int sc, input int hs,
                             input int click_a, input int click_b);
    for (int j = 0; j <= click_b; j++)
      add((j == click_a || j == click_b), 0, 0, 0, 0, s, bl, sc, hs);
    for (int j = 0; j < 4; j++)
      add(0, 0, 0, 0, 0, CLEAR, bl, sc, hs);
    add(0, 0, 0, 0, 0, PLAY, 3, 0, hs);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst              = 1'b0;
    bus.click        = 1'b1;
    bus.base1_nuked  = 1'b0;
    bus.base2_nuked  = 1'b0;
    bus.base3_nuked  = 1'b0;
    bus.killcount    = '0;

    // Click held through reset, then a clean press: MENU -> 4 cycles CLEAR -> PLAY.
    add(1, 0, 0, 0, 0, MENU, 3, 0, 0);
    add(1, 0, 0, 0, 0, MENU, 3, 0, 0);
    add(0, 0, 0, 0, 0, MENU, 3, 0, 0);
    add(1, 0, 0, 0, 0, MENU, 3, 0, 0);
    for (int j = 0; j < 4; j++) add(0, 0, 0, 0, 0, CLEAR, 3, 0, 0);
    add(0, 0, 0, 0, 0, PLAY, 3, 0, 0);
    // base2 pulsed three times, base1 held: each base counts once.
    for (int j = 0; j < 3; j++) begin
      add(0, 0, 1, 0, 0, PLAY, 2, 0, 0);
      add(0, 0, 0, 0, 0, PLAY, 2, 0, 0);
    end
    for (int j = 0; j < 20; j++) add(0, 1, 0, 0, 0, PLAY, 1, 0, 0);
    add(0, 0, 0, 0, 3, PLAY, 1, 3, 0);
    add(0, 0, 0, 1, 3, OVER, 0, 3, 3);
    // Click at 5 cycles into OVER is ignored; click at 12 restarts.
    add_restart(OVER, 0, 3, 3, 5, 12);
    // Killcount ramp to the win threshold.
    for (int k = 0; k < 5; k++) add(0, 0, 0, 0, k, PLAY, 3, k, 3);
    add(0, 0, 0, 0, 5, WIN, 3, 5, 5);
    // Rise landing one cycle before the holdoff completes is ignored; the next one is taken.
    add_restart(WIN, 3, 5, 5, 7, 9);
    // Lower score does not replace the best score.
    add(0, 1, 0, 0, 1, PLAY, 2, 1, 5);
    add(0, 0, 1, 1, 2, OVER, 0, 2, 5);
    add_restart(OVER, 0, 2, 5, -1, 10);
    // Last base and win threshold together: loss wins the tie.
    add(0, 1, 1, 0, 3, PLAY, 1, 3, 5);
    add(0, 0, 0, 1, 5, OVER, 0, 5, 5);
    add_restart(OVER, 0, 5, 5, -1, 10);
    add(0, 1, 0, 0, 4, PLAY, 2, 4, 5);

    @(negedge clk);
    chk_all("reset", MENU, 3, 0, 0);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      bus.click       = vecs[i].click;
      bus.base1_nuked = vecs[i].b1;
      bus.base2_nuked = vecs[i].b2;
      bus.base3_nuked = vecs[i].b3;
      bus.killcount   = vecs[i].kill;
      @(negedge clk);
      chk_all($sformatf("v%0d", i), vecs[i].st, int'(vecs[i].bases),
              int'(vecs[i].score), int'(vecs[i].high));
    end

    // Asynchronous reset mid-PLAY: takes effect before any clock edge.
    #2;
    rst = 1'b0;
    #1;
    chk_all("async_rst", MENU, 3, 0, 0);
    bus.base1_nuked = 1'b0;
    bus.killcount   = '0;
    bus.click       = 1'b0;
    @(negedge clk);
    chk_all("rst_held", MENU, 3, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk_all("rst_release", MENU, 3, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
